pipe_perf_monitor: RTL and testbench

//  Parametrised run-control and performance monitor for the pipelined CPU top.

---
 rtl/pipe_perf_monitor_pkg.sv | 21 ++
 rtl/pipe_perf_monitor_popcnt.sv | 18 +
 rtl/pipe_perf_monitor.sv | 110 +++++++++++
 tb/tb_pipe_perf_monitor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_perf_monitor_pkg.sv
// Shared definitions for the pipeline run-control / performance monitor:
// state encodings, counter select codes and the default finish-instruction signature.
package pipe_perf_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  localparam logic [1:0] SEL_CYC   = 2'd0;
  localparam logic [1:0] SEL_INST  = 2'd1;
  localparam logic [1:0] SEL_STALL = 2'd2;
  localparam logic [1:0] SEL_FLUSH = 2'd3;

  // The finish instruction is a self-branch; its WB pc+4 and encoding identify program end.
  localparam logic [31:0] FINISH_PC_4_DEF = 32'h0040_0054;
  localparam logic [31:0] FINISH_INST_DEF = 32'h1000_ffff;

endpackage

// File: rtl/pipe_perf_monitor_popcnt.sv
// Combinational population count of the per-stage flush lines.
module flush_popcnt #(
  parameter int FLUSH_W = 3
) (
  input  logic [FLUSH_W-1:0]             flush,
  output logic [$clog2(FLUSH_W+1)-1:0]   count
);

  localparam int CW = $clog2(FLUSH_W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < FLUSH_W; i++) begin
      count = count + CW'(flush[i]);
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Run-control and performance monitor: detects finish-instruction retirement,
// runs a stall watchdog and keeps cycle / retired / stall / flushed-slot counters.
module pipe_perf_monitor
  import pipe_perf_monitor_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int          FLUSH_W     = 3,
  parameter int          PIPE_DEPTH  = 5,
  parameter logic [31:0] FINISH_PC_4 = FINISH_PC_4_DEF,
  parameter logic [31:0] FINISH_INST = FINISH_INST_DEF,
  parameter int          WDOG_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               stall,
  input  logic [FLUSH_W-1:0] flush,
  input  logic [31:0]        wb_pc_4,
  input  logic [31:0]        wb_inst,
  input  logic [1:0]         rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic               finish,
  output logic               timeout,
  output logic               busy
);

  localparam int PC_W = $clog2(FLUSH_W + 1);
  // Instructions still filling the pipe are not yet retired, so inst starts negative.
  localparam logic [CNT_W-1:0]  INST_RST  = CNT_W'(1 - PIPE_DEPTH);
  localparam logic [WDOG_W-1:0] WDOG_ONES = '1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_ONES - WDOG_W'(1);

  mon_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cyc, inst, stl, fls;
  logic [WDOG_W-1:0] wdog;
  logic [PC_W-1:0]   pop;
  logic              any_flush, match, wdog_step, expire;

  flush_popcnt #(.FLUSH_W(FLUSH_W)) u_popcnt (
    .flush (flush),
    .count (pop)
  );

  assign any_flush = |flush;
  assign match     = (wb_pc_4 == FINISH_PC_4) && (wb_inst == FINISH_INST);
  assign wdog_step = stall && !any_flush;
  // Expiry is taken on the edge that brings wdog to all-ones.
  assign expire    = wdog_step && (wdog == WDOG_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (match)       state_nxt = ST_DONE;
        else if (expire) state_nxt = ST_TIMEOUT;
      end
      default: ;
    endcase
    if (clr) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= '0;
      inst <= INST_RST;
      stl  <= '0;
      fls  <= '0;
      wdog <= '0;
    end else if (clr) begin
      cyc  <= '0;
      inst <= INST_RST;
      stl  <= '0;
      fls  <= '0;
      wdog <= '0;
    end else if (state == ST_RUN) begin
      cyc <= cyc + CNT_W'(1);
      if (any_flush) begin
        inst <= inst + CNT_W'(1) - CNT_W'(pop);
        fls  <= fls + CNT_W'(pop);
      end else if (stall) begin
        stl  <= stl + CNT_W'(1);
      end else begin
        inst <= inst + CNT_W'(1);
      end
      wdog <= wdog_step ? wdog + WDOG_W'(1) : '0;
    end
  end

  always_comb begin
    rd_data = cyc;
    case (rd_sel)
      SEL_CYC:   rd_data = cyc;
      SEL_INST:  rd_data = inst;
      SEL_STALL: rd_data = stl;
      default:   rd_data = fls;
    endcase
  end

  assign busy    = (state == ST_RUN);
  assign finish  = (state == ST_DONE);
  assign timeout = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed self-checking bench for pipe_perf_monitor using three parameterisations
// driven by shared stimulus; expectations are queued then popped at each read.
module tb_pipe_perf_monitor;
  import pipe_perf_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, stall = 1'b0;
  logic [2:0]  flush = '0;
  logic [31:0] wb_pc_4 = 32'h0040_0000, wb_inst = 32'h0000_0013;
  logic [1:0]  rd_sel = '0;

  logic [31:0] rd_a, rd_b;
  logic [7:0]  rd_c;
  logic        finish_a, timeout_a, busy_a;
  logic        finish_b, timeout_b, busy_b;
  logic        finish_c, timeout_c, busy_c;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  pipe_perf_monitor u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .stall(stall), .flush(flush),
    .wb_pc_4(wb_pc_4), .wb_inst(wb_inst), .rd_sel(rd_sel), .rd_data(rd_a),
    .finish(finish_a), .timeout(timeout_a), .busy(busy_a)
  );

  pipe_perf_monitor #(.WDOG_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .stall(stall), .flush(flush),
    .wb_pc_4(wb_pc_4), .wb_inst(wb_inst), .rd_sel(rd_sel), .rd_data(rd_b),
    .finish(finish_b), .timeout(timeout_b), .busy(busy_b)
  );

  pipe_perf_monitor #(.CNT_W(8), .PIPE_DEPTH(3)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .stall(stall), .flush(flush),
    .wb_pc_4(wb_pc_4), .wb_inst(wb_inst), .rd_sel(rd_sel), .rd_data(rd_c),
    .finish(finish_c), .timeout(timeout_c), .busy(busy_c)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic e, input logic c, input logic s,
                               input logic [2:0] f, input logic m, input int n);
    en      = e;
    clr     = c;
    stall   = s;
    flush   = f;
    wb_pc_4 = m ? FINISH_PC_4_DEF : 32'h0040_0000;
    wb_inst = m ? FINISH_INST_DEF : 32'h0000_0013;
    tick(n);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic expectRead(input string tag, input int dut, input logic [1:0] sel,
                            input logic [31:0] exp);
    logic [31:0] obs;
    sb.push_back('{tag, exp});
    rd_sel = sel;
    #1;
    case (dut)
      0:       obs = rd_a;
      1:       obs = rd_b;
      default: obs = {24'h0, rd_c};
    endcase
    checkOutput(obs);
  endtask

  // Flags packed as {busy, finish, timeout}.
  task automatic expectFlags(input string tag, input int dut,
                             input logic b, input logic f, input logic t);
    logic [31:0] obs;
    sb.push_back('{tag, {29'h0, b, f, t}});
    #1;
    case (dut)
      0:       obs = {29'h0, busy_a, finish_a, timeout_a};
      1:       obs = {29'h0, busy_b, finish_b, timeout_b};
      default: obs = {29'h0, busy_c, finish_c, timeout_c};
    endcase
    checkOutput(obs);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 3'b000, 0, 10);
    expectFlags("t1_flags",   0, 0, 0, 0);
    expectRead ("t1_cyc",     0, SEL_CYC,   32'h0);
    expectRead ("t1_inst",    0, SEL_INST,  32'hFFFF_FFFC);
    expectRead ("t1_stl",     0, SEL_STALL, 32'h0);
    expectRead ("t1_fls",     0, SEL_FLUSH, 32'h0);
    expectRead ("t1_inst_c",  2, SEL_INST,  32'h0000_00FE);

    // Clean run to finish
    applyStimulus(1, 0, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 12);
    expectFlags("t2_running", 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 3'b000, 1, 1);
    expectFlags("t2_flags",   0, 0, 1, 0);
    expectRead ("t2_cyc",     0, SEL_CYC,   32'd13);
    expectRead ("t2_inst",    0, SEL_INST,  32'd9);
    expectRead ("t2_stl",     0, SEL_STALL, 32'd0);
    expectRead ("t2_fls",     0, SEL_FLUSH, 32'd0);
    applyStimulus(0, 0, 0, 3'b000, 0, 20);
    expectRead ("t2_cyc_frz", 0, SEL_CYC,   32'd13);
    expectRead ("t2_inst_frz",0, SEL_INST,  32'd9);
    expectFlags("t2_flags_frz", 0, 0, 1, 0);

    // Stalls, flush (with stall also high: flush wins), clean, then clr
    applyStimulus(0, 1, 0, 3'b000, 0, 1);
    applyStimulus(1, 0, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 1, 3'b000, 0, 3);
    applyStimulus(0, 0, 1, 3'b011, 0, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 2);
    expectRead ("t3_cyc",     0, SEL_CYC,   32'd6);
    expectRead ("t3_inst",    0, SEL_INST,  32'hFFFF_FFFD);
    expectRead ("t3_stl",     0, SEL_STALL, 32'd3);
    expectRead ("t3_fls",     0, SEL_FLUSH, 32'd2);
    applyStimulus(0, 1, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 1);
    expectFlags("t3_clr_flags", 0, 0, 0, 0);
    expectRead ("t3_clr_inst",  0, SEL_INST, 32'hFFFF_FFFC);
    expectRead ("t3_clr_cyc",   0, SEL_CYC,  32'd0);

    // Watchdog expiry on the small-watchdog instance
    applyStimulus(1, 0, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 1, 3'b000, 0, 6);
    expectFlags("t4_before",  1, 1, 0, 0);
    applyStimulus(0, 0, 1, 3'b000, 0, 1);
    expectFlags("t4_timeout", 1, 0, 0, 1);
    expectRead ("t4_stl",     1, SEL_STALL, 32'd7);
    applyStimulus(0, 0, 0, 3'b000, 1, 1);
    expectFlags("t4_match_ignored", 1, 0, 0, 1);
    expectRead ("t4_stl_frz", 1, SEL_STALL, 32'd7);
    expectRead ("t4_cyc_frz", 1, SEL_CYC,   32'd7);

    // Match on the same edge as watchdog expiry
    applyStimulus(0, 1, 0, 3'b000, 0, 1);
    applyStimulus(1, 0, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 1, 3'b000, 0, 6);
    applyStimulus(0, 0, 1, 3'b000, 1, 1);
    expectFlags("t5_done_wins", 1, 0, 1, 0);
    expectRead ("t5_stl",       1, SEL_STALL, 32'd7);

    // Narrow counters wrap; then asynchronous reset mid-run
    applyStimulus(0, 1, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 1);
    expectRead ("t6_inst_start", 2, SEL_INST, 32'h0000_00FE);
    applyStimulus(1, 0, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 300);
    expectRead ("t6_cyc_wrap",  2, SEL_CYC,  32'd44);
    expectRead ("t6_inst_wrap", 2, SEL_INST, 32'h0000_002A);
    expectRead ("t6_cyc_a",     0, SEL_CYC,  32'd300);
    expectFlags("t6_busy",      2, 1, 0, 0);
    rst_n = 1'b0;
    expectFlags("t6_rst_flags", 2, 0, 0, 0);
    expectRead ("t6_rst_cyc",   2, SEL_CYC,  32'd0);
    expectRead ("t6_rst_inst",  2, SEL_INST, 32'h0000_00FE);
    expectRead ("t6_rst_inst_a",0, SEL_INST, 32'hFFFF_FFFC);
    expectFlags("t6_rst_flags_b", 1, 0, 0, 0);
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
